// File: rtl/io_forward_history_pkg.sv
// Shared CPU data types and the IO-stage forwarding entry layout.
// cpu_core_params is the core-wide source; io_forward_params re-exports what forwarding needs.
package cpu_core_params;
  localparam int CPU_DATA_WIDTH = 32;
  typedef logic [CPU_DATA_WIDTH-1:0] cpu_data_t;
endpackage

package io_forward_params;
  typedef cpu_core_params::cpu_data_t cpu_data_t;
  localparam int CPU_DATA_WIDTH = cpu_core_params::CPU_DATA_WIDTH;

  localparam int REG_ADDR_WIDTH_DEFAULT = 5;
  localparam int STROBE_WIDTH_DEFAULT   = CPU_DATA_WIDTH / 8;
  localparam int DEPTH_MAX              = 8;

  typedef struct packed {
    logic                            valid;
    logic                            data_valid;
    logic [REG_ADDR_WIDTH_DEFAULT-1:0] register;
    logic [STROBE_WIDTH_DEFAULT-1:0] strobe;
    cpu_data_t                       data;
  } io_forward_entry_t;
endpackage

// File: rtl/io_forward_merge.sv
// One lookup port: per byte, take the youngest matching strobed entry, else the register-file byte.
module io_forward_merge
  import io_forward_params::*;
#(
  parameter int DEPTH          = 2,
  parameter int DATA_WIDTH     = CPU_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic [DEPTH-1:0]                     entry_valid,
  input  logic [DEPTH-1:0]                     entry_data_valid,
  input  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] entry_register,
  input  logic [DEPTH-1:0][STROBE_WIDTH-1:0]   entry_strobe,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     entry_data,
  input  logic [REG_ADDR_WIDTH-1:0]            query_register,
  input  logic [DATA_WIDTH-1:0]                register_file_data,
  output logic [DATA_WIDTH-1:0]                query_data,
  output logic                                 query_hit,
  output logic                                 query_stall
);

  logic [STROBE_WIDTH-1:0] supplied;
  logic                    query_enable;

  assign query_enable = (query_register != '0);

  // Scanning from entry 0 upward with a per-byte "already supplied" flag gives youngest-first priority.
  always_comb begin
    query_data  = register_file_data;
    supplied    = '0;
    query_stall = 1'b0;
    for (int b = 0; b < STROBE_WIDTH; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (query_enable && !supplied[b] && entry_valid[i] &&
            entry_register[i] == query_register && entry_strobe[i][b]) begin
          supplied[b]           = 1'b1;
          query_data[b*8 +: 8]  = entry_data[i][b*8 +: 8];
          query_stall           = query_stall | !entry_data_valid[i];
        end
      end
    end
    query_hit = |supplied;
  end

endmodule

// File: rtl/io_forward_history.sv
// N-deep IO->ID forwarding history with byte strobes, late load fill and flush.
// Entry index equals instruction age; non-writing pushes shift in bubbles.
module io_forward_history
  import io_forward_params::*;
#(
  parameter int DEPTH          = 2,
  parameter int READ_PORTS     = 2,
  parameter int DATA_WIDTH     = CPU_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 push_valid,
  input  logic                                 push_write_enabled,
  input  logic [REG_ADDR_WIDTH-1:0]            push_register,
  input  logic [DATA_WIDTH/8-1:0]              push_strobe,
  input  logic [DATA_WIDTH-1:0]                push_data,
  input  logic                                 push_data_valid,
  input  logic                                 fill_valid,
  input  logic [DATA_WIDTH-1:0]                fill_data,
  input  logic                                 flush,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] query_register,
  input  logic [READ_PORTS*DATA_WIDTH-1:0]     query_register_file_data,
  output logic [READ_PORTS*DATA_WIDTH-1:0]     query_data,
  output logic [READ_PORTS-1:0]                query_hit,
  output logic [READ_PORTS-1:0]                query_stall,
  output logic                                 pending_load
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  logic [DEPTH-1:0]                     valid_q, valid_d;
  logic [DEPTH-1:0]                     data_valid_q, data_valid_d;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] register_q, register_d;
  logic [DEPTH-1:0][STROBE_WIDTH-1:0]   strobe_q, strobe_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_q, data_d;

  logic                  fill_hit;
  logic                  head_data_valid;
  logic [DATA_WIDTH-1:0] head_data;

  assign fill_hit        = fill_valid && valid_q[0] && !data_valid_q[0];
  assign head_data_valid = data_valid_q[0] | fill_hit;
  assign head_data       = fill_hit ? fill_data : data_q[0];

  // Fill is folded into the head before shifting, so a fill racing a push lands at index 1.
  always_comb begin
    valid_d      = valid_q;
    data_valid_d = data_valid_q;
    register_d   = register_q;
    strobe_d     = strobe_q;
    data_d       = data_q;
    if (flush) begin
      valid_d      = '0;
      data_valid_d = '0;
    end else if (push_valid) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i]      = valid_q[i-1];
        register_d[i]   = register_q[i-1];
        strobe_d[i]     = strobe_q[i-1];
        data_valid_d[i] = (i == 1) ? head_data_valid : data_valid_q[i-1];
        data_d[i]       = (i == 1) ? head_data : data_q[i-1];
      end
      valid_d[0]      = push_write_enabled && (push_register != '0) && (push_strobe != '0);
      data_valid_d[0] = push_data_valid;
      register_d[0]   = push_register;
      strobe_d[0]     = push_strobe;
      data_d[0]       = push_data;
    end else if (fill_hit) begin
      data_valid_d[0] = 1'b1;
      data_d[0]       = fill_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      data_valid_q <= '0;
      register_q   <= '0;
      strobe_q     <= '0;
      data_q       <= '0;
    end else begin
      valid_q      <= valid_d;
      data_valid_q <= data_valid_d;
      register_q   <= register_d;
      strobe_q     <= strobe_d;
      data_q       <= data_d;
    end
  end

  assign pending_load = valid_q[0] && !data_valid_q[0];

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    io_forward_merge #(
      .DEPTH          (DEPTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .STROBE_WIDTH   (STROBE_WIDTH)
    ) u_merge (
      .entry_valid        (valid_q),
      .entry_data_valid   (data_valid_q),
      .entry_register     (register_q),
      .entry_strobe       (strobe_q),
      .entry_data         (data_q),
      .query_register     (query_register[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .register_file_data (query_register_file_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .query_data         (query_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .query_hit          (query_hit[p]),
      .query_stall        (query_stall[p])
    );
  end

endmodule

// File: tb/tb_io_forward_history.sv
// Directed bench for io_forward_history (DEPTH=2, two ports): vector table plus corner sequences.
module tb_io_forward_history;

  logic        clock;
  logic        reset;
  logic        push_valid, push_write_enabled, push_data_valid;
  logic [4:0]  push_register;
  logic [3:0]  push_strobe;
  logic [31:0] push_data;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic        flush;
  logic [9:0]  query_register;
  logic [63:0] query_register_file_data;
  logic [63:0] query_data;
  logic [1:0]  query_hit, query_stall;
  logic        pending_load;

  int n_checks = 0;
  int n_fail   = 0;

  io_forward_history #(.DEPTH(2), .READ_PORTS(2), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_write_enabled(push_write_enabled),
    .push_register(push_register), .push_strobe(push_strobe),
    .push_data(push_data), .push_data_valid(push_data_valid),
    .fill_valid(fill_valid), .fill_data(fill_data), .flush(flush),
    .query_register(query_register), .query_register_file_data(query_register_file_data),
    .query_data(query_data), .query_hit(query_hit), .query_stall(query_stall),
    .pending_load(pending_load)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        pv, we;
    logic [4:0]  rg;
    logic [3:0]  st;
    logic [31:0] d;
    logic        dv, fv;
    logic [31:0] fd;
    logic        fl;
    logic [4:0]  q0;
    logic [31:0] rf0, e0;
    logic        h0, s0;
    logic [4:0]  q1;
    logic [31:0] rf1, e1;
    logic        h1, s1, pend;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic pv, we, input logic [4:0] rg, input logic [3:0] st, input logic [31:0] d,
    input logic dv, fv, input logic [31:0] fd, input logic fl,
    input logic [4:0] q0, input logic [31:0] rf0, e0, input logic h0, s0,
    input logic [4:0] q1, input logic [31:0] rf1, e1, input logic h1, s1, pend);
    vec_t v;
    v.pv = pv; v.we = we; v.rg = rg; v.st = st; v.d = d; v.dv = dv; v.fv = fv; v.fd = fd; v.fl = fl;
    v.q0 = q0; v.rf0 = rf0; v.e0 = e0; v.h0 = h0; v.s0 = s0;
    v.q1 = q1; v.rf1 = rf1; v.e1 = e1; v.h1 = h1; v.s1 = s1; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    push_valid = 0; push_write_enabled = 0; push_register = 0; push_strobe = 0;
    push_data = 0; push_data_valid = 1; fill_valid = 0; fill_data = 0; flush = 0;
  endtask

  task automatic set_query(input logic [4:0] q0, input logic [31:0] rf0,
                           input logic [4:0] q1, input logic [31:0] rf1);
    query_register           = {q1, q0};
    query_register_file_data = {rf1, rf0};
  endtask

  task automatic do_push(input logic [4:0] rg, input logic [3:0] st, input logic [31:0] d,
                         input logic dv);
    push_valid = 1; push_write_enabled = 1; push_register = rg;
    push_strobe = st; push_data = d; push_data_valid = dv;
  endtask

  initial begin
    // Expected values describe state committed by earlier rows; each row's inputs take effect at its edge.
    //          pv we rg  st    data          dv fv fill          fl q0  rf0           e0            h0 s0 q1  rf1           e1            h1 s1 pend
    vecs[0]  = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 8,  32'h11223344, 32'h11223344, 0, 0, 0,  32'h99,       32'h99,       0, 0, 0);
    vecs[1]  = mk(1, 1, 8, 4'hF, 32'hAABBCCDD, 1, 0, 32'h0,        0, 8,  32'h11223344, 32'h11223344, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    vecs[2]  = mk(1, 1, 8, 4'h1, 32'h000000EE, 1, 0, 32'h0,        0, 8,  32'h11223344, 32'hAABBCCDD, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 8,  32'h11223344, 32'hAABBCCEE, 1, 0, 8,  32'h0,        32'hAABBCCEE, 1, 0, 0);
    vecs[4]  = mk(1, 1, 9, 4'hF, 32'h0,        0, 0, 32'h0,        0, 8,  32'h11223344, 32'hAABBCCEE, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    vecs[5]  = mk(1, 1, 3, 4'hF, 32'h33,       1, 1, 32'h12345678, 0, 9,  32'hFFFFFFFF, 32'h00000000, 1, 1, 8,  32'h01020304, 32'h010203EE, 1, 0, 1);
    vecs[6]  = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 9,  32'hFFFFFFFF, 32'h12345678, 1, 0, 3,  32'h0,        32'h33,       1, 0, 0);
    vecs[7]  = mk(1, 1, 4, 4'hF, 32'h1,        1, 0, 32'h0,        0, 9,  32'hFFFFFFFF, 32'h12345678, 1, 0, 8,  32'h01020304, 32'h01020304, 0, 0, 0);
    vecs[8]  = mk(1, 1, 5, 4'hF, 32'h2,        1, 0, 32'h0,        0, 4,  32'hCAFE,       32'h1,        1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    vecs[9]  = mk(1, 1, 6, 4'hF, 32'h3,        1, 0, 32'h0,        0, 4,  32'hCAFE,       32'h1,        1, 0, 5,  32'h0,        32'h2,        1, 0, 0);
    vecs[10] = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 4,  32'hCAFE,       32'hCAFE,     0, 0, 5,  32'h0,        32'h2,        1, 0, 0);
    vecs[11] = mk(1, 1, 9, 4'hF, 32'hDEAD0000, 0, 0, 32'h0,        0, 6,  32'h0,        32'h3,        1, 0, 5,  32'h0,        32'h2,        1, 0, 0);
    vecs[12] = mk(1, 1, 7, 4'hF, 32'h7,        1, 1, 32'h5A5A5A5A, 1, 9,  32'h0,        32'hDEAD0000, 1, 1, 6,  32'h0,        32'h3,        1, 0, 1);
    vecs[13] = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 7,  32'h44,       32'h44,       0, 0, 6,  32'h55,       32'h55,       0, 0, 0);
    vecs[14] = mk(1, 1, 10, 4'hF, 32'h5,       1, 0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0, 10, 32'h77,       32'h77,       0, 0, 0);
    vecs[15] = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0, 10, 32'h77,       32'h5,        1, 0, 0);
    vecs[16] = mk(1, 0, 10, 4'hF, 32'h99,      1, 0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0, 10, 32'h77,       32'h5,        1, 0, 0);
    vecs[17] = mk(1, 1, 0, 4'hF, 32'h88,       1, 0, 32'h0,        0, 0,  32'h123,      32'h123,      0, 0, 10, 32'h77,       32'h5,        1, 0, 0);
    vecs[18] = mk(1, 1, 12, 4'h0, 32'hFF,      1, 0, 32'h0,        0, 12, 32'h66,       32'h66,       0, 0, 10, 32'h77,       32'h77,       0, 0, 0);
    vecs[19] = mk(0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 12, 32'h66,       32'h66,       0, 0, 10, 32'h77,       32'h77,       0, 0, 0);

    idle_inputs();
    set_query(0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      push_valid = vecs[i].pv; push_write_enabled = vecs[i].we; push_register = vecs[i].rg;
      push_strobe = vecs[i].st; push_data = vecs[i].d; push_data_valid = vecs[i].dv;
      fill_valid = vecs[i].fv; fill_data = vecs[i].fd; flush = vecs[i].fl;
      set_query(vecs[i].q0, vecs[i].rf0, vecs[i].q1, vecs[i].rf1);
      #1;
      check($sformatf("v%0d data0", i),  query_data[31:0],  vecs[i].e0);
      check($sformatf("v%0d hit0", i),   {31'b0, query_hit[0]},   {31'b0, vecs[i].h0});
      check($sformatf("v%0d stall0", i), {31'b0, query_stall[0]}, {31'b0, vecs[i].s0});
      check($sformatf("v%0d data1", i),  query_data[63:32], vecs[i].e1);
      check($sformatf("v%0d hit1", i),   {31'b0, query_hit[1]},   {31'b0, vecs[i].h1});
      check($sformatf("v%0d stall1", i), {31'b0, query_stall[1]}, {31'b0, vecs[i].s1});
      check($sformatf("v%0d pending", i), {31'b0, pending_load}, {31'b0, vecs[i].pend});
      @(negedge clock);
    end

    // Halfword load filled late without a push; a later fill with nothing pending is ignored.
    idle_inputs();
    do_push(13, 4'h3, 32'h0, 1'b0);
    @(negedge clock);
    idle_inputs();
    set_query(13, 32'h11110000, 0, 0);
    #1;
    check("ld13 stall", {31'b0, query_stall[0]}, 32'h1);
    check("ld13 pending", {31'b0, pending_load}, 32'h1);
    fill_valid = 1; fill_data = 32'h0000ABCD;
    @(negedge clock);
    fill_valid = 1; fill_data = 32'h0000FFFF;
    #1;
    check("fill13 data", query_data[31:0], 32'h1111ABCD);
    check("fill13 stall", {31'b0, query_stall[0]}, 32'h0);
    check("fill13 pending", {31'b0, pending_load}, 32'h0);
    @(negedge clock);
    fill_valid = 0;
    #1;
    check("stale fill ignored", query_data[31:0], 32'h1111ABCD);

    // Asynchronous reset between edges clears state without waiting for a clock.
    @(negedge clock);
    do_push(14, 4'hF, 32'h14141414, 1'b0);
    set_query(14, 32'h0BADF00D, 13, 32'h11110000);
    @(posedge clock);
    #2;
    idle_inputs();
    check("pre-reset hit", {30'b0, query_hit}, 32'h3);
    reset = 1'b1;
    #1;
    check("async reset data0", query_data[31:0], 32'h0BADF00D);
    check("async reset hits", {30'b0, query_hit}, 32'h0);
    check("async reset stall", {30'b0, query_stall}, 32'h0);
    check("async reset pending", {31'b0, pending_load}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_forward_history.md
# io_forward_history

Parametrised forwarding history for the IO (memory) stage. It records the last DEPTH register-file writes that left IO toward WB, including byte-strobed partial writes (LWL/LWR, SB/SH-style merges) and loads whose data returns late. It answers READ_PORTS combinational lookups from ID, merging youngest-first per byte over the register-file value. It replaces the fixed current/previous pair on the IO→ID back-pass bus with an N-deep, multi-port, late-fill-capable structure.

## Interface
- DEPTH, 2: entries held; entry 0 is youngest; legal range 1..8.
- READ_PORTS, 2: independent ID lookup ports; at least 1.
- DATA_WIDTH, 32: equal to CPU_DATA_WIDTH; must be a multiple of 8; STROBE_WIDTH = DATA_WIDTH/8.
- REG_ADDR_WIDTH, 5: register address width.

- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all entries.
- push_valid  in  1  an instruction leaves IO toward WB this cycle (valid && WB allow-in).
- push_write_enabled  in  1  that instruction writes the register file.
- push_register  in  REG_ADDR_WIDTH  destination register.
- push_strobe  in  STROBE_WIDTH  byte write strobe.
- push_data  in  DATA_WIDTH  write data; bytes with strobe 0 are ignored.
- push_data_valid  in  1  0 = load data not yet returned.
- fill_valid  in  1  late load data for entry 0.
- fill_data  in  DATA_WIDTH  late data, pre-aligned to the strobed byte lanes.
- flush  in  1  exception/ERET flush.
- query_register  in  READ_PORTS*REG_ADDR_WIDTH  per-port source register.
- query_register_file_data  in  READ_PORTS*DATA_WIDTH  per-port register-file read value.
- query_data  out  READ_PORTS*DATA_WIDTH  merged operand.
- query_hit  out  READ_PORTS  at least one byte was forwarded.
- query_stall  out  READ_PORTS  a forwarded byte comes from an entry with data_valid = 0.
- pending_load  out  1  entry 0 valid && !data_valid.

## Operation
- Entry fields: valid, data_valid, register, strobe, data.
- Push: on push_valid, entries shift (i → i+1; entry DEPTH-1 is dropped).
  - Entry 0 is loaded with valid = push_write_enabled && push_register != 0 && push_strobe != 0.
  - A non-writing push shifts in an invalid bubble, so entry index equals instruction age.
- Fill: when fill_valid and entry 0 is valid with data_valid = 0, entry 0 data ← fill_data and data_valid ← 1. Otherwise fill is ignored.
- Simultaneous fill + push: fill applies first. The filled entry lands at index 1 and the new push goes to index 0.
- Flush: all valid bits clear next edge. Flush overrides push and fill in the same cycle.
  - Contract: the instantiating stage asserts flush only after all recorded writes are committed to the register file.
- Lookup (combinational, per port p, per byte b):
  - The supplier is the youngest valid entry with register == query_register[p] and strobe[b] = 1.
  - query_data byte b = supplier data byte, or the register-file byte if there is no supplier.
  - query_hit = any byte supplied.
  - query_stall = any supplier has data_valid = 0.
  - query_register = 0 gives hit = 0, stall = 0, and data = register-file value.
- Correctness condition: every register-file write must also pass through push, so entries never hold values shadowed by unrecorded writes.

## Timing
- Reset values: all entry valid/data_valid = 0, pending_load = 0. Query outputs follow combinationally: hit = 0, stall = 0, data = register-file input.
- Push/fill/flush become visible to lookups the cycle after the edge. There is no same-cycle bypass of push_data.
- Lookup latency: 0 cycles, combinational from query_register, query_register_file_data and state.
- Reset mid-operation clears state immediately, independent of clock.
- DEPTH = 1: push overwrites entry 0. A fill coinciding with a push is lost, because the filled entry is dropped.

## Structure
- Package io_forward_params:
  - io_forward_entry_t packed struct {valid, data_valid, register, strobe, data}, parametrised via the package's width constants.
  - It re-exports cpu_data_t and CPU_DATA_WIDTH from cpu_core_params.
- Sub-module io_forward_merge: combinational per-port byte priority merge producing data/hit/stall. It is instantiated READ_PORTS times in a generate loop.
- The top level holds the entry array, shift, fill and flush logic.

## Test plan
- Reset, then query r8 with register-file value 0x11223344 → hit 0, data 0x11223344.
- Push r8 strobe 0xF data 0xAABBCCDD, then push r8 strobe 0x1 data 0x000000EE; next cycle query r8 → data 0xAABBCCEE, hit 1.
- Push r9 load with data_valid = 0 → stall 1, pending_load 1. Next cycle fill 0x12345678 with a simultaneous push of r3 → following cycle r9 returns 0x12345678 with stall 0.
- DEPTH = 2: push r4 = 1, r5 = 2, r6 = 3 → r4 lookup misses (register-file value returned); r5 → 2, r6 → 3.
- Flush with a same-cycle push of r7 → all ports miss r7 next cycle, pending_load 0.
- Two ports query r0 and r10 concurrently with r10 = 0x5 recorded → port 0 hit 0, data 0; port 1 hit 1, data 0x5.
